// File: rtl/iterative_multdiv_unit.sv
// Iterative multiply / divide / remainder unit for the execute stage.
// One result bit per cycle: shift-add for MUL/MULU, restoring
// shift-subtract for DIV/REM. Sign handling is done on magnitudes in PREP
// and undone in FIX. A start/ready/ack handshake is used; flush aborts the
// operation without touching the reported result.
module iterative_multdiv_unit #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic [TAG_W-1:0] tag_in,
  input  logic             flush,
  input  logic             result_ack,
  output logic             in_ready,
  output logic             busy,
  output logic             result_valid,
  output logic [WIDTH-1:0] result,
  output logic             exception,
  output logic [TAG_W-1:0] tag_out
);

  localparam int CNT_W = $clog2(WIDTH);

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_MULU = 2'b01;
  localparam logic [1:0] OP_DIV  = 2'b10;
  localparam logic [1:0] OP_REM  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_RUN,
    S_FIX,
    S_DONE
  } state_e;

  state_e               state_q;
  logic [1:0]           op_q;
  logic [TAG_W-1:0]     tag_q;
  // Raw operands after accept; magnitudes after PREP. During RUN the
  // multiplier (opb_q) or the dividend (opa_q) is shifted out MSB first.
  logic [WIDTH-1:0]     opa_q;
  logic [WIDTH-1:0]     opb_q;
  logic                 neg_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [WIDTH-1:0]     result_q;
  logic                 exc_q;
  logic [TAG_W-1:0]     tag_out_q;

  logic                 is_div;
  logic                 signed_op;
  logic                 a_neg;
  logic                 b_neg;
  logic [WIDTH-1:0]     abs_a_d;
  logic [WIDTH-1:0]     abs_b_d;
  logic                 neg_d;
  logic [2*WIDTH-1:0]   mul_acc_d;
  logic [WIDTH:0]       div_trial;
  logic [WIDTH:0]       div_diff;
  logic                 div_ok;
  logic [2*WIDTH-1:0]   div_acc_d;
  logic [2*WIDTH-1:0]   prod_d;
  logic [WIDTH-1:0]     quo_d;
  logic [WIDTH-1:0]     rem_d;
  logic [WIDTH-1:0]     fix_result_d;
  logic                 fix_exc_d;

  // Status outputs come straight from the state register.
  assign in_ready     = (state_q == S_IDLE);
  assign busy         = (state_q == S_PREP) || (state_q == S_RUN) || (state_q == S_FIX);
  assign result_valid = (state_q == S_DONE);
  assign result       = result_q;
  assign exception    = exc_q;
  assign tag_out      = tag_out_q;

  // Magnitude/sign preparation, per-cycle iteration step and final fix-up.
  always_comb begin
    is_div    = op_q[1];
    signed_op = (op_q != OP_MULU);
    a_neg     = signed_op & opa_q[WIDTH-1];
    b_neg     = signed_op & opb_q[WIDTH-1];
    // The most-negative value maps onto 2^(WIDTH-1) read as unsigned.
    abs_a_d   = a_neg ? -opa_q : opa_q;
    abs_b_d   = b_neg ? -opb_q : opb_q;
    neg_d     = (op_q == OP_REM) ? a_neg : (a_neg ^ b_neg);

    // Shift-add, multiplier consumed MSB first.
    mul_acc_d = {acc_q[2*WIDTH-2:0], 1'b0}
              + (opb_q[WIDTH-1] ? {{WIDTH{1'b0}}, opa_q} : {(2*WIDTH){1'b0}});

    // Restoring step: partial remainder in the high half, quotient bits
    // shifting into the low half. |divisor| <= 2^(WIDTH-1) keeps the trial
    // value below 2^WIDTH, so bit WIDTH of the difference is the borrow.
    div_trial = {acc_q[2*WIDTH-1:WIDTH], opa_q[WIDTH-1]};
    div_diff  = div_trial - {1'b0, opb_q};
    div_ok    = ~div_diff[WIDTH];
    div_acc_d = {(div_ok ? div_diff[WIDTH-1:0] : div_trial[WIDTH-1:0]),
                 acc_q[WIDTH-2:0], div_ok};

    prod_d = neg_q ? -acc_q : acc_q;
    quo_d  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_d  = neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    fix_result_d = '0;
    fix_exc_d    = 1'b0;
    case (op_q)
      OP_MUL: begin
        fix_result_d = prod_d[WIDTH-1:0];
        fix_exc_d    = (prod_d[2*WIDTH-1:WIDTH] != {WIDTH{prod_d[WIDTH-1]}});
      end
      OP_MULU: begin
        fix_result_d = prod_d[WIDTH-1:0];
        fix_exc_d    = |prod_d[2*WIDTH-1:WIDTH];
      end
      OP_DIV: begin
        // Only most-negative / -1 yields a positive quotient of 2^(WIDTH-1);
        // the wrapped value is the most-negative word, flagged as overflow.
        fix_result_d = quo_d;
        fix_exc_d    = ~neg_q & acc_q[WIDTH-1];
      end
      OP_REM: begin
        fix_result_d = rem_d;
        fix_exc_d    = 1'b0;
      end
      default: begin
        fix_result_d = '0;
        fix_exc_d    = 1'b0;
      end
    endcase
  end

  // Control FSM with operand, accumulator and result registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      op_q      <= OP_MUL;
      tag_q     <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      neg_q     <= 1'b0;
      acc_q     <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      exc_q     <= 1'b0;
      tag_out_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && !flush) begin
            op_q    <= op;
            tag_q   <= tag_in;
            opa_q   <= operand_a;
            opb_q   <= operand_b;
            state_q <= S_PREP;
          end
        end
        S_PREP: begin
          if (flush) begin
            state_q <= S_IDLE;
          end else if (is_div && (opb_q == '0)) begin
            result_q  <= '0;
            exc_q     <= 1'b1;
            tag_out_q <= tag_q;
            state_q   <= S_DONE;
          end else begin
            opa_q   <= abs_a_d;
            opb_q   <= abs_b_d;
            neg_q   <= neg_d;
            acc_q   <= '0;
            cnt_q   <= CNT_W'(WIDTH - 1);
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          if (flush) begin
            state_q <= S_IDLE;
          end else begin
            if (is_div) begin
              acc_q <= div_acc_d;
              opa_q <= {opa_q[WIDTH-2:0], 1'b0};
            end else begin
              acc_q <= mul_acc_d;
              opb_q <= {opb_q[WIDTH-2:0], 1'b0};
            end
            if (cnt_q == '0) begin
              state_q <= S_FIX;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
        end
        S_FIX: begin
          if (flush) begin
            state_q <= S_IDLE;
          end else begin
            result_q  <= fix_result_d;
            exc_q     <= fix_exc_d;
            tag_out_q <= tag_q;
            state_q   <= S_DONE;
          end
        end
        S_DONE: begin
          if (flush || result_ack) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iterative_multdiv_unit.sv
// Directed bench for iterative_multdiv_unit: a WIDTH=32 and a WIDTH=8
// instance share clock and reset. Latency is counted in rising edges with
// the accept edge numbered 1, so a normal operation reports at edge
// WIDTH+3 and a divide-by-zero at edge 2.
module tb_iterative_multdiv_unit;

  logic        clk;
  logic        rst_n;

  logic        start32, flush32, ack32;
  logic [1:0]  op32;
  logic [31:0] a32, b32;
  logic [4:0]  tag32;
  logic        in_ready32, busy32, rv32, exc32;
  logic [31:0] res32;
  logic [4:0]  tag_out32;

  logic        start8, flush8, ack8;
  logic [1:0]  op8;
  logic [7:0]  a8, b8;
  logic [4:0]  tag8;
  logic        in_ready8, busy8, rv8, exc8;
  logic [7:0]  res8;
  logic [4:0]  tag_out8;

  int checks = 0;
  int errors = 0;

  logic [31:0] hold_res;
  logic        hold_exc;
  logic [4:0]  hold_tag;

  iterative_multdiv_unit #(.WIDTH(32), .TAG_W(5)) dut32 (
    .clock(clk), .reset(rst_n), .start(start32), .op(op32),
    .operand_a(a32), .operand_b(b32), .tag_in(tag32), .flush(flush32),
    .result_ack(ack32), .in_ready(in_ready32), .busy(busy32),
    .result_valid(rv32), .result(res32), .exception(exc32), .tag_out(tag_out32)
  );

  iterative_multdiv_unit #(.WIDTH(8), .TAG_W(5)) dut8 (
    .clock(clk), .reset(rst_n), .start(start8), .op(op8),
    .operand_a(a8), .operand_b(b8), .tag_in(tag8), .flush(flush8),
    .result_ack(ack8), .in_ready(in_ready8), .busy(busy8),
    .result_valid(rv8), .result(res8), .exception(exc8), .tag_out(tag_out8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Issue one operation on the 32-bit unit, wait for result_valid and check
  // latency, busy duration, result, exception and tag. With junk=1, start is
  // held high with different operands for the whole busy period.
  task automatic run_op32(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] t, input logic [31:0] exp_res, input logic exp_exc,
                          input int exp_lat, input bit junk, input string name);
    int edges;
    int busy_cnt;
    @(negedge clk);
    checks++;
    if (in_ready32 !== 1'b1) begin
      errors++;
      $display("FAIL %s in_ready before start: got %b want 1", name, in_ready32);
    end
    start32 = 1'b1; op32 = o; a32 = a; b32 = b; tag32 = t;
    @(posedge clk);
    edges = 1;
    busy_cnt = 0;
    #1;
    if (junk) begin
      op32 = 2'b10; a32 = 32'd100; b32 = 32'd7; tag32 = 5'd1;
    end else begin
      start32 = 1'b0;
    end
    while (rv32 !== 1'b1 && edges < 200) begin
      if (busy32 === 1'b1) busy_cnt++;
      @(posedge clk);
      edges++;
      #1;
    end
    start32 = 1'b0;
    checks++;
    if (edges != exp_lat) begin
      errors++;
      $display("FAIL %s latency: got %0d edges want %0d", name, edges, exp_lat);
    end
    checks++;
    if (busy_cnt != exp_lat - 1) begin
      errors++;
      $display("FAIL %s busy cycles: got %0d want %0d", name, busy_cnt, exp_lat - 1);
    end
    checks++;
    if (res32 !== exp_res) begin
      errors++;
      $display("FAIL %s result: got %h want %h", name, res32, exp_res);
    end
    checks++;
    if (exc32 !== exp_exc) begin
      errors++;
      $display("FAIL %s exception: got %b want %b", name, exc32, exp_exc);
    end
    checks++;
    if (tag_out32 !== t) begin
      errors++;
      $display("FAIL %s tag_out: got %0d want %0d", name, tag_out32, t);
    end
    $display("op32 %s: a=%h b=%h -> result=%h exc=%b tag=%0d latency=%0d",
             name, a, b, res32, exc32, tag_out32, edges);
    hold_res = exp_res;
    hold_exc = exp_exc;
    hold_tag = t;
  endtask

  task automatic do_ack32(input string name);
    @(negedge clk);
    ack32 = 1'b1;
    @(posedge clk);
    #1;
    ack32 = 1'b0;
    checks++;
    if (rv32 !== 1'b0 || in_ready32 !== 1'b1) begin
      errors++;
      $display("FAIL %s ack: got valid=%b ready=%b want valid=0 ready=1", name, rv32, in_ready32);
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (res32 !== 32'd0 || exc32 !== 1'b0 || tag_out32 !== 5'd0 || rv32 !== 1'b0 || busy32 !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got res=%h exc=%b tag=%0d valid=%b busy=%b want all 0",
               res32, exc32, tag_out32, rv32, busy32);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready32 !== 1'b1 || in_ready8 !== 1'b1) begin
      errors++;
      $display("FAIL reset_release in_ready: got %b/%b want 1/1", in_ready32, in_ready8);
    end
    $display("reset: outputs cleared, in_ready=%b", in_ready32);
  endtask

  task automatic test_mul_hold();
    run_op32(2'b00, 32'd7, 32'hFFFFFFFA, 5'd9, 32'hFFFFFFD6, 1'b0, 35, 1'b0, "mul_7x-6");
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (rv32 !== 1'b1 || res32 !== 32'hFFFFFFD6 || tag_out32 !== 5'd9 || exc32 !== 1'b0) begin
        errors++;
        $display("FAIL hold cycle %0d: got valid=%b res=%h tag=%0d exc=%b want 1 FFFFFFD6 9 0",
                 i, rv32, res32, tag_out32, exc32);
      end
    end
    do_ack32("mul_7x-6");
  endtask

  task automatic test_divrem();
    run_op32(2'b10, 32'd100, 32'd7, 5'd2, 32'd14, 1'b0, 35, 1'b0, "div_100/7");
    do_ack32("div_100/7");
    run_op32(2'b11, 32'hFFFFFF9C, 32'd7, 5'd3, 32'hFFFFFFFE, 1'b0, 35, 1'b0, "rem_-100/7");
    do_ack32("rem_-100/7");
    run_op32(2'b10, 32'hFFFFFF9C, 32'd7, 5'd4, 32'hFFFFFFF2, 1'b0, 35, 1'b0, "div_-100/7");
    do_ack32("div_-100/7");
    run_op32(2'b01, 32'hFFFFFFFF, 32'd2, 5'd5, 32'hFFFFFFFE, 1'b1, 35, 1'b0, "mulu_ovf");
    do_ack32("mulu_ovf");
  endtask

  task automatic test_boundaries();
    run_op32(2'b10, 32'd5, 32'd0, 5'd10, 32'd0, 1'b1, 2, 1'b0, "div_by_zero");
    do_ack32("div_by_zero");
    run_op32(2'b11, 32'd5, 32'd0, 5'd11, 32'd0, 1'b1, 2, 1'b0, "rem_by_zero");
    do_ack32("rem_by_zero");
    run_op32(2'b10, 32'h80000000, 32'hFFFFFFFF, 5'd12, 32'h80000000, 1'b1, 35, 1'b0, "div_minneg/-1");
    do_ack32("div_minneg/-1");
    run_op32(2'b11, 32'h80000000, 32'hFFFFFFFF, 5'd13, 32'd0, 1'b0, 35, 1'b0, "rem_minneg/-1");
    do_ack32("rem_minneg/-1");
    run_op32(2'b00, 32'h00010000, 32'h00010000, 5'd14, 32'd0, 1'b1, 35, 1'b0, "mul_2^32");
    do_ack32("mul_2^32");
    run_op32(2'b00, 32'h00008000, 32'hFFFF0000, 5'd15, 32'h80000000, 1'b0, 35, 1'b0, "mul_-2^31");
    do_ack32("mul_-2^31");
  endtask

  // Flush on RUN cycle 10, then an immediate new operation with start held
  // high throughout its busy period.
  task automatic test_flush_back_to_back();
    @(negedge clk);
    start32 = 1'b1; op32 = 2'b00; a32 = 32'd5; b32 = 32'd5; tag32 = 5'd3;
    @(posedge clk);
    #1;
    start32 = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (busy32 !== 1'b1) begin
      errors++;
      $display("FAIL flush pre-state busy: got %b want 1", busy32);
    end
    flush32 = 1'b1;
    @(posedge clk);
    #1;
    flush32 = 1'b0;
    checks++;
    if (rv32 !== 1'b0 || busy32 !== 1'b0 || in_ready32 !== 1'b1) begin
      errors++;
      $display("FAIL flush_run state: got valid=%b busy=%b ready=%b want 0 0 1", rv32, busy32, in_ready32);
    end
    checks++;
    if (res32 !== hold_res || exc32 !== hold_exc || tag_out32 !== hold_tag) begin
      errors++;
      $display("FAIL flush_run outputs: got res=%h exc=%b tag=%0d want %h %b %0d",
               res32, exc32, tag_out32, hold_res, hold_exc, hold_tag);
    end
    $display("flush in RUN cycle 10: valid=%b ready=%b", rv32, in_ready32);
    run_op32(2'b00, 32'd3, 32'd3, 5'd4, 32'd9, 1'b0, 35, 1'b1, "mul_3x3_after_flush");
    do_ack32("mul_3x3_after_flush");
  endtask

  task automatic test_flush_priority();
    run_op32(2'b10, 32'd100, 32'd7, 5'd6, 32'd14, 1'b0, 35, 1'b0, "div_for_flush_ack");
    @(negedge clk);
    flush32 = 1'b1;
    ack32 = 1'b1;
    @(posedge clk);
    #1;
    flush32 = 1'b0;
    ack32 = 1'b0;
    checks++;
    if (rv32 !== 1'b0 || in_ready32 !== 1'b1 || res32 !== 32'd14 || tag_out32 !== 5'd6) begin
      errors++;
      $display("FAIL flush_ack_done: got valid=%b ready=%b res=%h tag=%0d want 0 1 0000000e 6",
               rv32, in_ready32, res32, tag_out32);
    end
    @(negedge clk);
    start32 = 1'b1; flush32 = 1'b1; op32 = 2'b00; a32 = 32'd2; b32 = 32'd2; tag32 = 5'd7;
    @(posedge clk);
    #1;
    start32 = 1'b0;
    flush32 = 1'b0;
    checks++;
    if (busy32 !== 1'b0 || in_ready32 !== 1'b1) begin
      errors++;
      $display("FAIL start_with_flush: got busy=%b ready=%b want 0 1", busy32, in_ready32);
    end
    $display("flush priority: ack+flush -> ready=%b, start+flush -> busy=%b", in_ready32, busy32);
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    start32 = 1'b1; op32 = 2'b00; a32 = 32'd7; b32 = 32'd7; tag32 = 5'd8;
    @(posedge clk);
    #1;
    start32 = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (res32 !== 32'd0 || exc32 !== 1'b0 || tag_out32 !== 5'd0 || busy32 !== 1'b0 || rv32 !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got res=%h exc=%b tag=%0d busy=%b valid=%b want all 0",
               res32, exc32, tag_out32, busy32, rv32);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready32 !== 1'b1) begin
      errors++;
      $display("FAIL async_reset release in_ready: got %b want 1", in_ready32);
    end
    $display("async reset mid-RUN: busy=%b ready=%b", busy32, in_ready32);
  endtask

  task automatic run_op8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] exp_res,
                         input logic exp_exc, input int exp_lat, input string name);
    int edges;
    @(negedge clk);
    start8 = 1'b1; op8 = 2'b10; a8 = a; b8 = b; tag8 = 5'd21;
    @(posedge clk);
    edges = 1;
    #1;
    start8 = 1'b0;
    while (rv8 !== 1'b1 && edges < 100) begin
      @(posedge clk);
      edges++;
      #1;
    end
    checks++;
    if (edges != exp_lat) begin
      errors++;
      $display("FAIL %s latency: got %0d edges want %0d", name, edges, exp_lat);
    end
    checks++;
    if (res8 !== exp_res || exc8 !== exp_exc || tag_out8 !== 5'd21) begin
      errors++;
      $display("FAIL %s: got res=%h exc=%b tag=%0d want %h %b 21", name, res8, exc8, tag_out8, exp_res, exp_exc);
    end
    $display("op8 %s: a=%h b=%h -> result=%h exc=%b latency=%0d", name, a, b, res8, exc8, edges);
    @(negedge clk);
    ack8 = 1'b1;
    @(posedge clk);
    #1;
    ack8 = 1'b0;
  endtask

  task automatic test_width8();
    run_op8(8'h80, 8'h03, 8'hD6, 1'b0, 11, "div8_-128/3");
    run_op8(8'h80, 8'hFF, 8'h80, 1'b1, 11, "div8_-128/-1");
  endtask

  initial begin
    rst_n = 1'b0;
    start32 = 1'b0; flush32 = 1'b0; ack32 = 1'b0; op32 = 2'b00; a32 = '0; b32 = '0; tag32 = '0;
    start8 = 1'b0; flush8 = 1'b0; ack8 = 1'b0; op8 = 2'b00; a8 = '0; b8 = '0; tag8 = '0;
    hold_res = '0; hold_exc = 1'b0; hold_tag = '0;
    test_reset();
    test_mul_hold();
    test_divrem();
    test_boundaries();
    test_flush_back_to_back();
    test_flush_priority();
    test_async_reset();
    test_width8();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/iterative_multdiv_unit.md
Name: iterative_multdiv_unit

Overview:
- Parametrised multicycle multiply/divide/remainder unit for the pipelined processor's execute stage.
- Replaces the fixed 32-bit mult/div stall helper.
- Adds a start/ready/ack handshake, unsigned and remainder modes, a destination tag, explicit exception reporting, and flush.
- The `busy` output drives the pipeline stall; the result is written back by tag.

Parameters:
WIDTH  32  operand/result width in bits (>=4)
TAG_W  5   width of destination-register tag carried with the operation

Ports:
clock         in   1        master clock, rising edge
reset         in   1        asynchronous, active-low; 0 clears all state immediately
start         in   1        request; accepted only when in_ready=1
op            in   2        00 MUL (signed, low half), 01 MULU (unsigned, low half), 10 DIV (signed quotient), 11 REM (signed remainder)
operand_a     in   WIDTH    multiplicand / dividend
operand_b     in   WIDTH    multiplier / divisor
tag_in        in   TAG_W    destination tag, captured on accept
flush         in   1        abort in-flight operation (branch/exception squash)
result_ack    in   1        consumer takes result; meaningful only when result_valid=1
in_ready      out  1        1 only in IDLE
busy          out  1        1 in PREP, RUN, FIX; used as pipeline stall
result_valid  out  1        1 only in DONE
result        out  WIDTH    result word, held stable while result_valid=1
exception     out  1        valid with result_valid: overflow or divide-by-zero
tag_out       out  TAG_W    tag of the operation being reported

Behaviour:
- Reset (reset=0, any time, asynchronous):
  - state=IDLE; result=0; tag_out=0; exception=0.
  - result_valid=0; busy=0; in_ready=1 once reset deasserts.
- States: IDLE, PREP, RUN, FIX, DONE. Transitions happen on the clock edge.
- IDLE -> PREP when start=1 and flush=0.
  - Operands, op and tag are captured at this edge.
  - start=1 in any other state is ignored, with no side effects.
- PREP (1 cycle):
  - Forms absolute values for signed ops and records the result sign.
  - Clears the 2*WIDTH accumulator and loads the iteration counter with WIDTH-1.
  - DIV/REM with operand_b=0: go to DONE directly with result=0, exception=1.
  - Otherwise go to RUN.
- RUN (exactly WIDTH cycles, one bit per cycle):
  - MUL/MULU: shift-add.
  - DIV/REM: restoring shift-subtract.
  - Counter decrements each cycle; RUN -> FIX when the counter reaches 0.
- FIX (1 cycle): applies sign correction, selects the result, evaluates exception, then goes to DONE.
  - MUL: result = low WIDTH bits of the signed product. exception=1 if the high WIDTH bits are not all copies of result[WIDTH-1].
  - MULU: result = low WIDTH bits. exception=1 if any high bit is nonzero.
  - DIV: quotient truncated toward zero.
    - Special case operand_a = most-negative and operand_b = -1: result = most-negative, exception=1.
  - REM: remainder takes the sign of the dividend, |rem| < |divisor|.
    - Most-negative rem -1: result=0, exception=0.
- DONE:
  - result, exception and tag_out are held stable.
  - DONE -> IDLE on result_ack=1; result_valid drops at that edge.
  - A new start is not accepted in the same cycle as the ack.
- Latency:
  - result_valid rises WIDTH+3 edges after the accept edge (PREP, WIDTH×RUN, FIX).
  - Divide-by-zero: rises 2 edges after accept.
- flush=1 on any edge in PREP/RUN/FIX/DONE: state -> IDLE.
  - result_valid=0 and busy=0 after that edge.
  - result, exception and tag_out are not updated.
  - flush=1 coincident with start in IDLE: start is rejected.
  - flush wins over result_ack in the same cycle; the effect is identical.
- busy, in_ready and result_valid are decoded from registered state only, with no combinational path from inputs.
- Outputs in IDLE keep the last result, exception and tag.

Test Plan:
- WIDTH=32: MUL 7 × -6, tag 9 → result_valid high exactly 35 cycles after accept; result=0xFFFFFFD6 (-42), exception=0, tag_out=9; busy high for 34 cycles. Hold ack low 5 cycles → outputs stable; ack → back to IDLE.
- DIV 100/7 → 14; REM -100/7 → -2 (0xFFFFFFFE); DIV -100/7 → -14; MULU 0xFFFFFFFF × 2 → 0xFFFFFFFE with exception=1. All with latency 35.
- DIV 5/0 and REM 5/0 → result_valid 2 cycles after accept; result=0, exception=1. DIV 0x80000000 / -1 → 0x80000000, exception=1. REM of the same operands → 0, exception=0.
- MUL 0x00010000 × 0x00010000 → result=0, exception=1. MUL 0x00008000 × 0xFFFF0000 (-2^31) → 0x80000000, exception=0.
- Flush on RUN cycle 10 → IDLE next edge, no result_valid. Immediate new start MUL 3 × 3 → 9 after 35 cycles. start asserted during busy → ignored, operands unchanged.
- reset driven low mid-RUN between edges → outputs cleared immediately; after release, in_ready=1.
- WIDTH=8 instance: DIV -128 / 3 → -42 (0xD6) after 11 cycles; DIV -128 / -1 → exception=1, result 0x80.
